// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: accepts note-on/note-off events one at a time
// and maintains per-slot note/velocity/held state with oldest-voice stealing.
// Ports:
//   clock, reset_l               - clock, asynchronous active-low reset
//   event_valid/event_ready      - event handshake (ready only while idle)
//   event_on/note/velocity       - event payload (velocity 0 means note-off)
//   voice_active/note/velocity   - per-slot held flag, note and velocity
//   event_done, stolen           - one-cycle pulses when an update lands
module voice_allocator #(
  parameter int ELEMENT_WIDTH = 7,
  parameter int ELEMENT_COUNT = 4
) (
  input  logic                                         clock,
  input  logic                                         reset_l,
  input  logic                                         event_valid,
  output logic                                         event_ready,
  input  logic                                         event_on,
  input  logic [ELEMENT_WIDTH-1:0]                     event_note,
  input  logic [6:0]                                   event_velocity,
  output logic [ELEMENT_COUNT-1:0]                     voice_active,
  output logic [ELEMENT_COUNT-1:0][ELEMENT_WIDTH-1:0]  voice_note,
  output logic [ELEMENT_COUNT-1:0][6:0]                voice_velocity,
  output logic                                         event_done,
  output logic                                         stolen
);

  localparam int unsigned AW = (ELEMENT_COUNT > 1) ? $clog2(ELEMENT_COUNT) : 1;
  localparam int unsigned VW = 7;

  typedef enum logic {IDLE = 1'b0, UPDATE = 1'b1} state_e;

  state_e                                     state_q, state_d;
  logic                                       ready_q;
  logic                                       accept;

  logic                                       ev_on_q;
  logic [ELEMENT_WIDTH-1:0]                   ev_note_q;
  logic [VW-1:0]                              ev_vel_q;

  logic [ELEMENT_COUNT-1:0]                   active_q, active_d;
  logic [ELEMENT_COUNT-1:0][ELEMENT_WIDTH-1:0] note_q, note_d;
  logic [ELEMENT_COUNT-1:0][VW-1:0]           vel_q, vel_d;
  logic [ELEMENT_COUNT-1:0][AW-1:0]           age_q, age_d;
  logic                                       done_q, done_d;
  logic                                       stolen_q, stolen_d;

  logic                                       eff_on;
  logic [ELEMENT_COUNT-1:0]                   hit_oh, free_oh, old_oh;
  logic                                       any_hit, any_free;

  assign accept = event_valid && (state_q == IDLE);

  // State register
  always_ff @(posedge clock or negedge reset_l) begin
    if (!reset_l) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = UPDATE;
      UPDATE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Event capture and voice/status registers
  always_ff @(posedge clock or negedge reset_l) begin
    if (!reset_l) begin
      ready_q   <= 1'b1;
      ev_on_q   <= 1'b0;
      ev_note_q <= '0;
      ev_vel_q  <= '0;
      active_q  <= '0;
      note_q    <= '0;
      vel_q     <= '0;
      age_q     <= '0;
      done_q    <= 1'b0;
      stolen_q  <= 1'b0;
    end else begin
      ready_q  <= (state_d == IDLE);
      if (accept) begin
        ev_on_q   <= event_on;
        ev_note_q <= event_note;
        ev_vel_q  <= event_velocity;
      end
      active_q <= active_d;
      note_q   <= note_d;
      vel_q    <= vel_d;
      age_q    <= age_d;
      done_q   <= done_d;
      stolen_q <= stolen_d;
    end
  end

  // Slot search: lowest-index active match, lowest-index free slot, oldest slot
  always_comb begin
    eff_on  = ev_on_q && (ev_vel_q != '0);
    hit_oh  = '0;
    free_oh = '0;
    old_oh  = '0;
    for (int i = ELEMENT_COUNT - 1; i >= 0; i--) begin
      if (active_q[i] && (note_q[i] == ev_note_q)) begin
        hit_oh    = '0;
        hit_oh[i] = 1'b1;
      end
      if (!active_q[i]) begin
        free_oh    = '0;
        free_oh[i] = 1'b1;
      end
      // Ages are distinct, so when every slot is held exactly one has the max age
      if (active_q[i] && (age_q[i] == AW'(ELEMENT_COUNT - 1))) begin
        old_oh    = '0;
        old_oh[i] = 1'b1;
      end
    end
    any_hit  = |hit_oh;
    any_free = |free_oh;
  end

  // Output / datapath logic: apply the registered event while in UPDATE
  always_comb begin
    logic [ELEMENT_COUNT-1:0] tgt_oh;
    logic                     fresh;
    logic [AW-1:0]            prev_age;

    active_d = active_q;
    note_d   = note_q;
    vel_d    = vel_q;
    age_d    = age_q;
    done_d   = 1'b0;
    stolen_d = 1'b0;
    tgt_oh   = '0;
    fresh    = 1'b0;
    prev_age = '0;

    if (state_q == UPDATE) begin
      done_d = 1'b1;
      if (eff_on) begin
        if (any_hit) begin
          tgt_oh = hit_oh;
        end else if (any_free) begin
          tgt_oh = free_oh;
          fresh  = 1'b1;
        end else begin
          tgt_oh   = old_oh;
          stolen_d = 1'b1;
        end
        for (int i = 0; i < ELEMENT_COUNT; i++) begin
          if (tgt_oh[i]) prev_age = age_q[i];
        end
        // Written slot becomes youngest; only slots younger than it age by one
        for (int i = 0; i < ELEMENT_COUNT; i++) begin
          if (tgt_oh[i]) begin
            active_d[i] = 1'b1;
            note_d[i]   = ev_note_q;
            vel_d[i]    = ev_vel_q;
            age_d[i]    = '0;
          end else if (active_q[i] && (fresh || (age_q[i] < prev_age))) begin
            age_d[i] = age_q[i] + AW'(1);
          end
        end
      end else if (any_hit) begin
        for (int i = 0; i < ELEMENT_COUNT; i++) begin
          if (hit_oh[i]) prev_age = age_q[i];
        end
        // Released slot keeps note/velocity; older slots close the age gap
        for (int i = 0; i < ELEMENT_COUNT; i++) begin
          if (hit_oh[i]) begin
            active_d[i] = 1'b0;
            age_d[i]    = '0;
          end else if (active_q[i] && (age_q[i] > prev_age)) begin
            age_d[i] = age_q[i] - AW'(1);
          end
        end
      end
    end
  end

  assign event_ready    = ready_q;
  assign voice_active   = active_q;
  assign voice_note     = note_q;
  assign voice_velocity = vel_q;
  assign event_done     = done_q;
  assign stolen         = stolen_q;

endmodule

// File: doc/voice_allocator.md
VOICE_ALLOCATOR -- requirements
Module: voice_allocator

Interface
REQ-001 SHALL have parameter ELEMENT_WIDTH, default 7, note number width.
REQ-002 SHALL have parameter ELEMENT_COUNT, default 4, number of voice slots (>=2).
REQ-003 SHALL have port clock  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port reset_l  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port event_valid  input  1  note event offered.
REQ-006 SHALL have port event_ready  output  1  allocator can accept an event.
REQ-007 SHALL have port event_on  input  1  1=note-on, 0=note-off.
REQ-008 SHALL have port event_note  input  ELEMENT_WIDTH  note number.
REQ-009 SHALL have port event_velocity  input  7  velocity.
REQ-010 SHALL have port voice_active  output  ELEMENT_COUNT  per-slot held flag.
REQ-011 SHALL have port voice_note  output  [ELEMENT_COUNT][ELEMENT_WIDTH]  per-slot note.
REQ-012 SHALL have port voice_velocity  output  [ELEMENT_COUNT][7]  per-slot velocity.
REQ-013 SHALL have port event_done  output  1  one-cycle pulse when an event's update lands.
REQ-014 SHALL have port stolen  output  1  one-cycle pulse, coincident with event_done, when a held voice was overwritten.

Function
REQ-015 SHALL use FSM states IDLE and UPDATE; event_ready=1 only in IDLE.
REQ-016 SHALL accept an event on a rising edge where event_valid & event_ready, register event_on/note/velocity, and go IDLE->UPDATE.
REQ-017 SHALL, in UPDATE, apply the registered event on the next edge, pulse event_done and stolen (if applicable) during the cycle after that edge, and return to IDLE; acceptance-to-update latency = 2 edges.
REQ-018 SHALL ignore event inputs while event_ready=0; events SHALL NOT be queued.
REQ-019 SHALL treat note-on with velocity 0 as note-off.
REQ-020 SHALL, on note-on whose note matches an active slot, overwrite that slot's velocity only (retrigger); no second slot is used.
REQ-021 SHALL, on note-on with no active match and >=1 inactive slot, write note and velocity into the lowest-index inactive slot and set its active bit.
REQ-022 SHALL, on note-on with all slots active and no match, steal the slot with the greatest age, write it, and assert stolen.
REQ-023 SHALL keep a per-slot age of width $clog2(ELEMENT_COUNT): the written slot's age becomes 0; every other active slot with age below the written slot's previous age (or every other active slot for a newly filled slot) increments by 1; active ages are always distinct and <= ELEMENT_COUNT-1.
REQ-024 SHALL, on note-off matching an active slot, clear that slot's active bit and age; voice_note/voice_velocity retain their values (release tail); the ages of other slots that were above it decrement by 1.
REQ-025 SHALL, on note-off with no active match, change no state but still pulse event_done.
REQ-026 SHALL only compare note matches against active slots; inactive slots' stale notes never match.
REQ-027 SHALL register all outputs; event_ready derives only from FSM state.

Reset
REQ-028 SHALL, while reset_l=0, force FSM=IDLE, event_ready=1, voice_active=0, all voice_note=0, all voice_velocity=0, all ages=0, event_done=0, stolen=0.
REQ-029 SHALL abandon any event in UPDATE when reset_l asserts mid-operation; no slot is written.
REQ-030 SHALL accept events on the first rising edge after reset_l deasserts.

Verification (ELEMENT_COUNT=4, ELEMENT_WIDTH=7)
REQ-031 SHALL check: note-on 60/v100 after reset -> 2 edges later voice_active=0001, voice_note[0]=60, event_done pulse, event_ready low exactly 1 cycle.
REQ-032 SHALL check: note-on 60,62,64,65 then note-on 67 -> slot 0 (oldest) gets 67, stolen pulses, voice_active=1111.
REQ-033 SHALL check: slots hold 60,62,64 active; note-on 62/v50 -> slot 1 velocity=50, no new slot, stolen=0; then note-on 67/v10 -> slot 3 (lowest free) filled; then note-on 69/v10 -> slot 0 stolen (62's age was reset by retrigger).
REQ-034 SHALL check: note-off 62 with 62 in slot 1 -> voice_active bit1=0, voice_note[1] still 62; note-off 99 -> no change, event_done pulses; note-on 62/v0 acts as note-off.
REQ-035 SHALL check: event_valid held high continuously -> one event accepted every 2 cycles, none duplicated or lost.
REQ-036 SHALL check: reset_l low during UPDATE -> all outputs at reset values, target slot untouched after reset releases.
